// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Single-outstanding data-memory responder for the CPU MEM
//               stage. Accepts one word request over a valid/ready handshake,
//               performs the read or write LATENCY edges after the accept, then
//               holds the response until the requester takes it.
//               Optional macro DMEM_MISALIGN_CHECK_EN: misaligned requests skip
//               the memory and return resp_err = 1 with zero data.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state;
  state_t              next_state;
  logic [3:0]          cnt;
  logic                lat_we;
  logic [ADDR_W-1:0]   lat_idx;
  logic [31:0]         lat_wdata;
  logic                accept;
  logic                enter_resp;
  logic                resp_done;
  logic                misalign;
  logic [31:0]         mem [DEPTH];

  // Address bits that never select a word are deliberately dropped; this sink
  // keeps that intent visible.
  logic                unused_addr_bits;

`ifdef DMEM_MISALIGN_CHECK_EN
  logic [1:0]          lat_off;
  assign misalign         = |lat_off;
  assign unused_addr_bits = ^req_addr[31:ADDR_W+2];
`else
  assign misalign         = 1'b0;
  assign unused_addr_bits = ^{req_addr[31:ADDR_W+2], req_addr[1:0]};
`endif

  assign req_ready  = (state == IDLE);
  assign accept     = req_valid && req_ready;
  // Every latency value passes through WAIT so the response lands exactly
  // LATENCY edges after the accept edge (cnt starts at LATENCY-1 and the
  // transition fires once it has counted down to zero).
  assign enter_resp = (state == WAIT) && (cnt == 4'd0);
  assign resp_done  = (state == RESP) && resp_ready;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req_valid)     next_state = WAIT;
      WAIT:    if (cnt == 4'd0)   next_state = RESP;
      RESP:    if (resp_ready)    next_state = IDLE;
      default:                    next_state = IDLE;
    endcase
  end

  // Request latch, latency counter and response registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt        <= 4'd0;
      lat_we     <= 1'b0;
      lat_idx    <= '0;
      lat_wdata  <= 32'h0;
`ifdef DMEM_MISALIGN_CHECK_EN
      lat_off    <= 2'b00;
`endif
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        lat_we    <= req_we;
        lat_idx   <= req_addr[ADDR_W+1:2];
        lat_wdata <= req_wdata;
`ifdef DMEM_MISALIGN_CHECK_EN
        lat_off   <= req_addr[1:0];
`endif
        cnt       <= 4'(LATENCY - 1);
      end else if ((state == WAIT) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end

      if (enter_resp) begin
        resp_valid <= 1'b1;
        resp_err   <= misalign;
        resp_rdata <= (lat_we || misalign) ? 32'h0 : mem[lat_idx];
      end else if (resp_done) begin
        resp_valid <= 1'b0;
        resp_err   <= 1'b0;
      end
    end
  end

  // Store commit on the edge entering RESP; the array itself is never reset,
  // and a reset during WAIT leaves state != WAIT so the store is dropped.
  always_ff @(posedge clock) begin
    if (enter_resp && lat_we && !misalign) begin
      mem[lat_idx] <= lat_wdata;
    end
  end

endmodule
`default_nettype wire
